vga_frame_dbuf: RTL and testbench
=================================

# vga_frame_dbuf

Double-buffered, parametrised VGA frame buffer. Two equal-size banks: the pixel producer writes the back bank while the scan-out path reads the front bank. Banks swap only on a frame boundary, after a handshake, so a frame never tears. The read side takes raw pixel coordinates from the timing generator, downscales them by a power-of-two factor, and returns the pixel value with fixed latency. Blanking is substituted outside the active area.

## Interface
- `DATA_WIDTH`, 2 — bits per stored pixel
- `H_RES`, 640 — active pixels per line
- `V_RES`, 480 — active lines per frame
- `SCALE_SHIFT`, 1 — downscale per axis is 2^SCALE_SHIFT; stored frame is (H_RES>>S)×(V_RES>>S)
- `ADDR_WIDTH`, 17 — bank address width; must satisfy 2^ADDR_WIDTH ≥ DEPTH = (H_RES>>S)*(V_RES>>S)
- `COORD_WIDTH`, 10 — width of rd_x/rd_y
- `BLANK_VALUE`, 0 — rd_data value outside active/valid region

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `wr_en` in 1 — write strobe, back bank
- `wr_addr` in ADDR_WIDTH — back-bank address
- `wr_data` in DATA_WIDTH — pixel value
- `swap_req` in 1 — request bank swap at the next frame boundary
- `vsync_start` in 1 — one-cycle frame-boundary pulse from the timing generator
- `swap_pending` out 1 — a swap request has been accepted and is waiting for a boundary
- `swap_done` out 1 — one-cycle pulse in the cycle the banks swap
- `front_bank` out 1 — index of the bank currently scanned out
- `rd_x`, `rd_y` in COORD_WIDTH — raw pixel coordinates
- `rd_de` in 1 — display enable for rd_x/rd_y
- `rd_data` out DATA_WIDTH — pixel value or BLANK_VALUE
- `rd_valid` out 1 — rd_data holds a stored pixel

## Operation
- **Memory:** 2×DEPTH words, addressed as {bank, addr}. Contents are not reset.
- **Write path:**
  - On `wr_en`, writes `wr_data` to {~front_bank, wr_addr}.
  - Writes with `wr_addr` ≥ DEPTH are ignored.
  - The bank select is the registered `front_bank` value, so a write in the swap cycle lands in the old back bank.
- **Swap FSM**, states IDLE and PENDING:
  - IDLE, `swap_req`=1 → PENDING, regardless of `vsync_start` in the same cycle. The swap then happens at the *next* boundary.
  - PENDING, `vsync_start`=1 → toggle `front_bank`, pulse `swap_done`, → IDLE.
  - `swap_req` in PENDING is ignored (no queuing).
  - `swap_pending` = (state == PENDING).
- **Read path:**
  - Valid read when `rd_de` && `rd_x` < H_RES && `rd_y` < V_RES.
  - addr = (rd_y>>S)*(H_RES>>S) + (rd_x>>S).
  - Bank is `front_bank`, sampled together with the coordinates.
  - Invalid reads give `rd_data`=BLANK_VALUE and `rd_valid`=0.
- **Collisions:** read and write always target different banks, so there is no read/write collision.
- **Reset (asynchronous, any time, including PENDING):**
  - Outputs: `rd_data`=BLANK_VALUE, `rd_valid`=0, `front_bank`=0, `swap_pending`=0, `swap_done`=0.
  - FSM returns to IDLE and the read pipeline is flushed.

## Timing
- **Read latency is 3 cycles**, fully pipelined, one read per cycle:
  - C1: register scaled coordinates, the valid flag and the bank; compute row base = sy*(H_RES>>S).
  - C2: register the full address.
  - C3: registered RAM output, muxed with BLANK_VALUE into `rd_data`; `rd_valid` registered alongside.
- **Write:** effective at the clock edge where `wr_en`=1; visible to reads after the following swap.
- **Swap:** `front_bank` changes and `swap_done` pulses on the edge after the `vsync_start` cycle in PENDING. Reads sampled from that edge onward use the new bank.
- **Multiplier:** only the C1 constant multiply, width ADDR_WIDTH.

## Structure
- **Package `vga_pkg`:** default H_RES/V_RES, swap FSM state enum (SWAP_IDLE, SWAP_PENDING), helper function for DEPTH.
- **Sub-module `vga_fb_ram`:** simple dual-port RAM, registered read, one write port, 2×DEPTH words.
- **Top level:** FSM, address pipeline and blank mux.

## Test plan
All scenarios use default parameters (S=1, DEPTH=76800).
- **Basic swap and scale.**
  - Stimulus: after reset, write addr 0=3 and addr 1=2, pulse `swap_req`, then `vsync_start`.
  - Required response: `front_bank`=1 and one `swap_done` pulse.
  - Then read (0,0), (1,1), (2,0) with `rd_de`=1: `rd_data` is 3, 3, 2 with `rd_valid`=1, each 3 cycles after its input.
- **Held request.** Stimulus: `swap_req`, then 100 cycles without `vsync_start`. Required response: `swap_pending`=1 and `front_bank` unchanged throughout; a `vsync_start` then swaps it.
- **Same-cycle event.** Stimulus: `swap_req` and `vsync_start` in the same cycle from IDLE. Required response: no swap; the swap occurs at the next `vsync_start`.
- **Blank and out-of-range.** Stimulus: a read with `rd_de`=0, then with `rd_x`=640, then with `rd_y`=480. Required response: `rd_data`=0, `rd_valid`=0 three cycles later, in each case.
- **Write isolation.** Stimulus: writes to the back bank at the address currently being read. Required response: the read returns the front-bank value unchanged; a write with `wr_addr`=76800 alters nothing.
- **Reset mid-operation.** Stimulus: `reset_n` low while PENDING with reads in flight. Required response: `swap_pending`, `front_bank`, `rd_valid` and `swap_done` go to 0 and `rd_data` to BLANK_VALUE immediately, without a clock edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the double-buffered VGA frame buffer.
//   - default active resolution
//   - swap FSM state encoding
//   - fb_depth(): words per bank for a given resolution and downscale shift
package vga_pkg;

    localparam int unsigned DEF_H_RES = 640;
    localparam int unsigned DEF_V_RES = 480;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_e;

    // Words in one bank: the stored frame is downscaled on both axes.
    function automatic int unsigned fb_depth(input int unsigned h_res,
                                             input int unsigned v_res,
                                             input int unsigned shift);
        return (h_res >> shift) * (v_res >> shift);
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port frame RAM holding two banks of DEPTH words each.
// Ports:
//   clk                        - clock, write and registered read on rising edge
//   wr_en, wr_bank, wr_addr,   - write port; caller guarantees wr_addr < DEPTH
//   wr_data
//   rd_bank, rd_addr           - read address, sampled on the rising edge
//   rd_data                    - registered read data (one cycle latency)
// Contents are not reset.
module vga_fb_ram
    import vga_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DEPTH      = 76800
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH:0] BANK_OFS = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [2*DEPTH];

    logic [ADDR_WIDTH:0] wr_idx;
    logic [ADDR_WIDTH:0] rd_idx;

    // Banks are packed back to back, so bank 1 starts at DEPTH rather than 2^ADDR_WIDTH.
    always_comb begin
        wr_idx = {1'b0, wr_addr} + (wr_bank ? BANK_OFS : '0);
        rd_idx = {1'b0, rd_addr} + (rd_bank ? BANK_OFS : '0);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/vga_frame_dbuf.sv
// Double-buffered VGA frame buffer.
// The producer writes the back bank; scan-out reads the front bank. Banks swap only on a
// vsync_start pulse after a swap_req, so a displayed frame never tears.
// Ports:
//   clk, reset_n               - clock; asynchronous active-low reset
//   wr_en, wr_addr, wr_data    - back-bank write; addresses >= DEPTH are dropped
//   swap_req, vsync_start      - swap request and frame-boundary pulse
//   swap_pending, swap_done,   - swap status; front_bank is the scanned-out bank
//   front_bank
//   rd_x, rd_y, rd_de          - raw coordinates and display enable
//   rd_data, rd_valid          - pixel (or BLANK_VALUE) three cycles after rd_x/rd_y
module vga_frame_dbuf
    import vga_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 2,
    parameter int unsigned           H_RES       = DEF_H_RES,
    parameter int unsigned           V_RES       = DEF_V_RES,
    parameter int unsigned           SCALE_SHIFT = 1,
    parameter int unsigned           ADDR_WIDTH  = 17,
    parameter int unsigned           COORD_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] BLANK_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   swap_req,
    input  logic                   vsync_start,
    output logic                   swap_pending,
    output logic                   swap_done,
    output logic                   front_bank,
    input  logic [COORD_WIDTH-1:0] rd_x,
    input  logic [COORD_WIDTH-1:0] rd_y,
    input  logic                   rd_de,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid
);

    localparam int unsigned DEPTH = fb_depth(H_RES, V_RES, SCALE_SHIFT);

    localparam logic [ADDR_WIDTH:0]  DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ROW_LEN  = ADDR_WIDTH'(H_RES >> SCALE_SHIFT);
    localparam logic [COORD_WIDTH:0] H_LIM     = (COORD_WIDTH + 1)'(H_RES);
    localparam logic [COORD_WIDTH:0] V_LIM     = (COORD_WIDTH + 1)'(V_RES);

    // ---------------------------------------------------------------------------------------
    // Swap FSM
    // ---------------------------------------------------------------------------------------
    swap_state_e state;
    logic        swap_now;
    logic        front_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SWAP_IDLE;
            front_bank <= 1'b0;
            swap_done  <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                // A vsync_start in the same cycle as the request does not count.
                SWAP_IDLE: begin
                    if (swap_req) begin
                        state <= SWAP_PENDING;
                    end
                end
                SWAP_PENDING: begin
                    if (vsync_start) begin
                        state      <= SWAP_IDLE;
                        front_bank <= ~front_bank;
                        swap_done  <= 1'b1;
                    end
                end
                default: state <= SWAP_IDLE;
            endcase
        end
    end

    assign swap_pending = (state == SWAP_PENDING);
    assign swap_now     = swap_pending && vsync_start;
    // A read sampled on the swap edge already belongs to the new front bank.
    assign front_next   = front_bank ^ swap_now;

    // ---------------------------------------------------------------------------------------
    // Write path: bank select is the registered front_bank, so a write on the swap edge
    // still lands in the bank that was back up to that edge.
    // ---------------------------------------------------------------------------------------
    logic ram_we;

    assign ram_we = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);

    // ---------------------------------------------------------------------------------------
    // Read pipeline
    // ---------------------------------------------------------------------------------------
    logic                   rd_ok;
    logic [COORD_WIDTH-1:0] sx_q;
    logic [COORD_WIDTH-1:0] sy_q;
    logic                   valid1_q;
    logic                   bank1_q;
    logic [ADDR_WIDTH-1:0]  row_base;
    logic [ADDR_WIDTH-1:0]  addr2_q;
    logic                   valid2_q;
    logic                   bank2_q;
    logic                   valid3_q;
    logic [DATA_WIDTH-1:0]  ram_rd_data;

    assign rd_ok    = rd_de && ({1'b0, rd_x} < H_LIM) && ({1'b0, rd_y} < V_LIM);
    assign row_base = ADDR_WIDTH'(sy_q) * ROW_LEN;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q     <= '0;
            sy_q     <= '0;
            valid1_q <= 1'b0;
            bank1_q  <= 1'b0;
            addr2_q  <= '0;
            valid2_q <= 1'b0;
            bank2_q  <= 1'b0;
            valid3_q <= 1'b0;
        end else begin
            sx_q     <= rd_x >> SCALE_SHIFT;
            sy_q     <= rd_y >> SCALE_SHIFT;
            valid1_q <= rd_ok;
            bank1_q  <= front_next;
            addr2_q  <= row_base + ADDR_WIDTH'(sx_q);
            valid2_q <= valid1_q;
            bank2_q  <= bank1_q;
            valid3_q <= valid2_q;
        end
    end

    vga_fb_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_we),
        .wr_bank(~front_bank),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_bank(bank2_q),
        .rd_addr(addr2_q),
        .rd_data(ram_rd_data)
    );

    // valid3_q is reset asynchronously, so rd_data blanks immediately on reset.
    assign rd_data  = valid3_q ? ram_rd_data : BLANK_VALUE;
    assign rd_valid = valid3_q;

endmodule

// File: tb/tb_vga_frame_dbuf.sv
// Self-checking bench for vga_frame_dbuf at default parameters.
module tb_vga_frame_dbuf;

    localparam int DEPTH = 76800;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [16:0] wr_addr;
    logic [1:0] wr_data;
    logic       swap_req;
    logic       vsync_start;
    logic       swap_pending;
    logic       swap_done;
    logic       front_bank;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       rd_de;
    logic [1:0] rd_data;
    logic       rd_valid;

    vga_frame_dbuf dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .vsync_start (vsync_start),
        .swap_pending(swap_pending),
        .swap_done   (swap_done),
        .front_bank  (front_bank),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_de       (rd_de),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic       de;
        logic [1:0] d;
        logic       v;
    } vec_t;

    typedef struct {
        logic [1:0] d;
        logic       v;
        int         due;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    // Reference model state
    logic [1:0] mem_m [int];
    int         fb_m = 0;
    bit         pend_m = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (swap_done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop each expectation on the negedge of the cycle it becomes due.
    always @(negedge clk) begin
        if (reset_n && sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e.d));
            chk("rd_valid", 32'(rd_valid), 32'(e.v));
        end
    end

    // One cycle of stimulus. push: queue an expected read result;
    // use_model: derive it from the model, else use ed/ev.
    task automatic drive(input logic we, input int wa, input logic [1:0] wd,
                         input logic sr, input logic vs,
                         input int x, input int y, input logic de,
                         input logic push, input logic use_model,
                         input logic [1:0] ed, input logic ev);
        exp_t e;
        bit   ok;
        int   a;
        @(posedge clk);
        #1;
        wr_en       = we;
        wr_addr     = wa[16:0];
        wr_data     = wd;
        swap_req    = sr;
        vsync_start = vs;
        rd_x        = x[9:0];
        rd_y        = y[9:0];
        rd_de       = de;
        if (we && wa < DEPTH) mem_m[(1 - fb_m) * DEPTH + wa] = wd;
        if (pend_m && vs) begin
            fb_m   = 1 - fb_m;
            pend_m = 0;
        end else if (!pend_m && sr) begin
            pend_m = 1;
        end
        if (push) begin
            if (use_model) begin
                ok  = de && x < 640 && y < 480;
                a   = (y >> 1) * 320 + (x >> 1);
                e.d = ok ? mem_m[fb_m * DEPTH + a] : 2'd0;
                e.v = ok;
            end else begin
                e.d = ed;
                e.v = ev;
            end
            e.due = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int x, input int y);
        drive(0, 0, 0, 0, 0, x, y, 1, 1, 1, 0, 0);
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int d0;

        vecs[0] = '{x: 0,   y: 0,   de: 1, d: 2'd3, v: 1};
        vecs[1] = '{x: 1,   y: 1,   de: 1, d: 2'd3, v: 1};
        vecs[2] = '{x: 2,   y: 0,   de: 1, d: 2'd2, v: 1};
        vecs[3] = '{x: 3,   y: 1,   de: 1, d: 2'd2, v: 1};
        vecs[4] = '{x: 0,   y: 0,   de: 0, d: 2'd0, v: 0};
        vecs[5] = '{x: 640, y: 0,   de: 1, d: 2'd0, v: 0};
        vecs[6] = '{x: 0,   y: 480, de: 1, d: 2'd0, v: 0};

        wr_en = 0; wr_addr = '0; wr_data = '0; swap_req = 0; vsync_start = 0;
        rd_x = '0; rd_y = '0; rd_de = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_data", 32'(rd_data), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_front_bank", 32'(front_bank), 0);
        chk("reset_swap_pending", 32'(swap_pending), 0);
        chk("reset_swap_done", 32'(swap_done), 0);
        reset_n = 1'b1;

        // Basic swap and scale
        drive(1, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("pending_after_req", 32'(swap_pending), 1);
        chk("front_before_vsync", 32'(front_bank), 0);
        d0 = done_cnt;
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("front_after_swap", 32'(front_bank), 1);
        chk("pending_after_swap", 32'(swap_pending), 0);
        idle(3);
        chk("swap_done_pulses", 32'(done_cnt - d0), 1);

        // Table of reads, back to back
        foreach (vecs[i])
            drive(0, 0, 0, 0, 0, vecs[i].x, vecs[i].y, vecs[i].de, 1, 0, vecs[i].d, vecs[i].v);
        idle(4);

        // Held request: no swap without a boundary
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (swap_pending !== 1'b1 || front_bank !== 1'b1) bad++;
        end
        chk("held_cycles_bad", 32'(bad), 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("held_then_swap", 32'(front_bank), 32'(fb_m));

        // Same-cycle request and boundary from idle
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("same_cycle_no_swap", 32'(front_bank), 0);
        chk("same_cycle_pending", 32'(swap_pending), 1);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("same_cycle_next_swap", 32'(front_bank), 1);

        // Write isolation: back-bank writes at the address being read, then an
        // out-of-range write that would alias the front bank if not dropped
        drive(1, 0, 2'd1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        drive(1, DEPTH, 2'd0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
        drive(1, 1, 2'd0, 0, 0, 2, 0, 1, 1, 1, 0, 0);
        rd(0, 0);
        rd(1, 0);
        idle(4);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("iso_front", 32'(front_bank), 0);
        rd(0, 0);
        rd(2, 0);
        rd(1, 1);
        idle(4);

        // Reset mid-operation: go to front 1, make pending, keep reads in flight
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0);
        rd(1, 1);
        rd(2, 0);
        rd(0, 0);
        rd(3, 1);
        chk("pre_reset_valid", 32'(rd_valid), 1);
        chk("pre_reset_pending", 32'(swap_pending), 1);
        chk("pre_reset_front", 32'(front_bank), 1);
        #1;
        sb.delete();
        reset_n = 1'b0;
        #1;
        chk("async_rd_data", 32'(rd_data), 0);
        chk("async_rd_valid", 32'(rd_valid), 0);
        chk("async_front_bank", 32'(front_bank), 0);
        chk("async_swap_pending", 32'(swap_pending), 0);
        chk("async_swap_done", 32'(swap_done), 0);
        fb_m   = 0;
        pend_m = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        // Bank 0 contents survive reset: addr 0 holds 1 there
        rd(0, 0);
        idle(5);
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
